// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage miniRV pipeline: stalls, flushes, forwarding, valids.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_rf_we,
  input  logic            id_is_load,
  input  logic            ex_redirect,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            id_byp_a,
  output logic            id_byp_b,
  output logic            ex_valid,
  output logic            mem_valid,
  output logic            wb_valid
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, LU_STALL} state_t;

  state_t          state;
  logic            id_valid;
  logic [RA_W-1:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic            ex_we, ex_load, ex_rs1_used, ex_rs2_used;
  logic            mem_we, mem_load, wb_we;
  logic            redirect, load_use;

  function automatic logic [1:0] fwd_sel(
    input logic            used,
    input logic [RA_W-1:0] rs,
    input logic            mv,
    input logic            mw,
    input logic            ml,
    input logic [RA_W-1:0] mrd,
    input logic            wv,
    input logic            ww,
    input logic [RA_W-1:0] wrd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && rs != '0) begin
      // A load in MEM has no data yet, so the older WB copy is the only candidate.
      if (mv && mw && !ml && mrd == rs)
        sel = 2'b01;
      else if (wv && ww && wrd == rs)
        sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    redirect = ex_redirect & ex_valid;
    load_use = (state == RUN) & ex_valid & ex_load & ex_we & (ex_rd != '0) &
               ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

    pc_stall    = load_use & ~redirect;
    if_id_stall = load_use & ~redirect;
    if_id_flush = (state == BOOT) | redirect;
    id_ex_flush = redirect | load_use;

    fwd_a_sel = fwd_sel(ex_rs1_used, ex_rs1, mem_valid, mem_we, mem_load, mem_rd,
                        wb_valid, wb_we, wb_rd);
    fwd_b_sel = fwd_sel(ex_rs2_used, ex_rs2, mem_valid, mem_we, mem_load, mem_rd,
                        wb_valid, wb_we, wb_rd);

    id_byp_a = wb_valid & wb_we & (wb_rd != '0) & (wb_rd == id_rs1);
    id_byp_b = wb_valid & wb_we & (wb_rd != '0) & (wb_rd == id_rs2);
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state       <= BOOT;
      id_valid    <= 1'b0;
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_we       <= 1'b0;
      ex_load     <= 1'b0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
      mem_valid   <= 1'b0;
      mem_rd      <= '0;
      mem_we      <= 1'b0;
      mem_load    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_we       <= 1'b0;
    end else begin
      case (state)
        BOOT:     state <= RUN;
        RUN:      state <= (load_use && !redirect) ? LU_STALL : RUN;
        LU_STALL: state <= RUN;
        default:  state <= RUN;
      endcase

      // id_valid tracks whether IF/ID holds a real fetch: bubble on flush, hold on stall.
      if (if_id_flush)
        id_valid <= 1'b0;
      else if (!if_id_stall)
        id_valid <= 1'b1;

      ex_valid    <= id_valid & ~id_ex_flush;
      ex_rd       <= id_rd;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_we       <= id_rf_we;
      ex_load     <= id_is_load;
      ex_rs1_used <= id_rs1_used;
      ex_rs2_used <= id_rs2_used;

      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_we    <= ex_we;
      mem_load  <= ex_load;

      wb_valid <= mem_valid;
      wb_rd    <= mem_rd;
      wb_we    <= mem_we;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  // CNT_W only sizes the perf counters; nothing to build in this configuration.
  if (CNT_W == 0) begin : g_no_cnt
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage miniRV pipeline (IF/ID/EX/MEM/WB).
- Keeps shadow copies of each stage's destination register, write-enable, load flag and valid bit.
- Drives the PC and pipeline-register stall/flush controls and the EX-stage and ID-stage forwarding selects.
- Supplies a per-stage valid flag, so bubbles never write the register file and never appear on the debug trace.

Parameters:
RA_W, 5, register address width
CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
cpu_clk  in  1  clock, all state updates on rising edge
cpu_rst  in  1  asynchronous active-high reset
id_rs1  in  RA_W  rs1 of instruction in ID
id_rs2  in  RA_W  rs2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_rd  in  RA_W  destination of ID instruction
id_rf_we  in  1  ID instruction writes RF
id_is_load  in  1  ID instruction is a load (rf_wsel selects DRAM data)
ex_redirect  in  1  branch taken or jal/jalr resolved in EX
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX (rf_we=0, ram_we=0)
fwd_a_sel  out  2  EX operand A: 00 ID/EX rD1, 01 EX/MEM ALU_C, 10 MEM/WB wD
fwd_b_sel  out  2  EX rD2/B source, same encoding; not applied when alub_sel selects the immediate
id_byp_a  out  1  ID rD1 taken from WB wD (RF write/read same cycle)
id_byp_b  out  1  ID rD2 taken from WB wD
ex_valid  out  1  EX holds a real instruction
mem_valid  out  1  MEM holds a real instruction
wb_valid  out  1  WB holds a real instruction; drives debug_wb_have_inst

Behaviour:
Reset
- cpu_rst=1 clears all valid bits and shadow registers.
- All outputs 0, except if_id_flush=1, because the first IF/ID content is invalid.
- FSM enters BOOT.

FSM states
- BOOT: one cycle; id_valid goes to 1 at the next edge; then RUN.
- RUN: normal operation.
- LU_STALL: exactly one cycle.

Load-use detection
- Condition: in RUN, ex_valid & shadow EX is_load & EX rf_we & EX rd≠0, and (id_rs1_used & id_rs1==EX rd, or id_rs2_used & id_rs2==EX rd).
- Response: pc_stall=1, if_id_stall=1, id_ex_flush=1, go to LU_STALL.
- LU_STALL: stall outputs 0; return to RUN. The load is now in MEM; the consumer enters EX when the load reaches WB, so it takes fwd=10.

Redirect
- Condition: ex_redirect & ex_valid.
- Response: if_id_flush=1 and id_ex_flush=1 in the same cycle; 2-cycle penalty.
- ex_redirect is ignored when ex_valid=0.
- Redirect beats a simultaneous load-use stall: stalls are forced to 0 and FSM goes to RUN.

Forwarding
- Applies to the EX instruction's shadow rs1/rs2, where the register is used and ≠0.
- EX/MEM match with mem_valid & we, and the MEM instruction not a load → 01.
- Otherwise, MEM/WB match with wb_valid & we → 10.
- Otherwise → 00.
- The youngest producer wins.
- x0 is never forwarded.

ID bypass
- id_byp_a/b=1 when wb_valid & WB we & WB rd≠0 & WB rd==id_rs.

Shadow pipeline advance (each edge)
- ID→EX, unless id_ex_flush; a flush inserts valid=0.
- EX→MEM and MEM→WB always advance.
- During a stall the ID shadow holds.

Reset mid-operation
- Asynchronous clear of every valid bit and the FSM.
- No partial writes are reported afterwards.

Optional Feature:
HAZARD_PERF_CNT_EN
- When defined, adds output ports stall_cnt[CNT_W] and flush_cnt[CNT_W].
- stall_cnt counts cycles with pc_stall=1.
- flush_cnt counts accepted redirects.
- Both saturate at all-ones and clear on cpu_rst.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: cpu_rst pulse mid-run → all valids 0, fwd sels 00, if_id_flush=1 one cycle, FSM in BOOT; wb_valid first reaches 1 at the 5th edge after the reset release.
2. ALU chain `add x5,…` then `add x6,x5,x1` → fwd_a_sel=01 in the consumer's EX cycle; x5 in both MEM and WB → 01 (youngest wins); producer rd=x0 → 00.
3. `lw x7` then `addi x8,x7,1` → one cycle with pc_stall=if_id_stall=id_ex_flush=1, then fwd_a_sel=10; ex_valid=0 for the bubble; with the feature on, stall_cnt=1.
4. Taken `beq` asserting ex_redirect → if_id_flush=id_ex_flush=1 for one cycle; the next two wb_valid slots are 0; flush_cnt increments by 1.
5. Redirect with a load-use condition in the same cycle → pc_stall=0, both flushes=1; ex_redirect with ex_valid=0 → no flush.
6. WB writes x9 while ID reads x9 → id_byp_a=1; WB rd=x0 → id_byp_a=0.
